// File: rtl/qpi_phy_generic_4x.sv
// Primitive-free QSPI PHY in the 4x clock domain: serializes each 1x word onto the pads
// one nibble slot per cycle and deserializes delayed pad samples back into a 16-bit RX word.
module qpi_phy_generic_4x #(
  parameter int N_CS      = 1,
  parameter int PHY_DELAY = 4
) (
  input  logic            clk_4x_s,
  input  logic            rst,
  input  logic            sync_4x,
  input  logic [15:0]     phy_io_o,
  input  logic [3:0]      phy_io_oe,
  input  logic [3:0]      phy_clk_o,
  input  logic [N_CS-1:0] phy_cs_o,
  output logic [15:0]     phy_io_i,
  output logic            phy_rx_stb,
  output logic [3:0]      pad_io_o,
  output logic [3:0]      pad_io_oe,
  input  logic [3:0]      pad_io_i,
  output logic            pad_clk,
  output logic [N_CS-1:0] pad_cs_n,
  output logic            sync_err
);

  localparam int DL = 5 + PHY_DELAY;

  typedef enum logic [1:0] {IDLE, S1, S2, S3} tx_state_t;

  tx_state_t   state;
  logic [11:0] tx_io;
  logic [2:0]  tx_oe;
  logic [2:0]  tx_clk;

  logic [3:0]    samp;
  logic [11:0]   hist;
  logic [DL-1:0] sync_dl;

  // Slot 0 goes straight from the phy inputs; only slots 1..3 need to be held in tx regs.
  always_ff @(posedge clk_4x_s) begin
    if (rst) begin
      state     <= IDLE;
      tx_io     <= '0;
      tx_oe     <= '0;
      tx_clk    <= '0;
      pad_io_o  <= '0;
      pad_io_oe <= '0;
      pad_clk   <= 1'b0;
      pad_cs_n  <= '1;
      sync_err  <= 1'b0;
    end else if (sync_4x) begin
      if (state == S1 || state == S2)
        sync_err <= 1'b1;
      tx_io     <= phy_io_o[15:4];
      tx_oe     <= phy_io_oe[3:1];
      tx_clk    <= phy_clk_o[3:1];
      pad_io_o  <= phy_io_o[3:0];
      pad_io_oe <= {4{phy_io_oe[0]}};
      pad_clk   <= phy_clk_o[0];
      pad_cs_n  <= ~phy_cs_o;
      state     <= S1;
    end else begin
      case (state)
        S1: begin
          pad_io_o  <= tx_io[3:0];
          pad_io_oe <= {4{tx_oe[0]}};
          pad_clk   <= tx_clk[0];
          state     <= S2;
        end
        S2: begin
          pad_io_o  <= tx_io[7:4];
          pad_io_oe <= {4{tx_oe[1]}};
          pad_clk   <= tx_clk[1];
          state     <= S3;
        end
        S3: begin
          pad_io_o  <= tx_io[11:8];
          pad_io_oe <= {4{tx_oe[2]}};
          pad_clk   <= tx_clk[2];
          state     <= IDLE;
        end
        default: begin
          pad_io_oe <= '0;
          pad_clk   <= 1'b0;
          pad_cs_n  <= '1;
          state     <= IDLE;
        end
      endcase
    end
  end

  // The sync delay line times the RX word; samp/hist always hold the last four pad samples.
  always_ff @(posedge clk_4x_s) begin
    if (rst) begin
      samp       <= '0;
      hist       <= '0;
      sync_dl    <= '0;
      phy_io_i   <= '0;
      phy_rx_stb <= 1'b0;
    end else begin
      samp       <= pad_io_i;
      hist       <= {hist[7:0], samp};
      sync_dl    <= {sync_dl[DL-2:0], sync_4x};
      phy_rx_stb <= sync_dl[DL-1];
      if (sync_dl[DL-1])
        phy_io_i <= {samp, hist[3:0], hist[7:4], hist[11:8]};
    end
  end

endmodule

// File: tb/tb_qpi_phy_generic_4x.sv
// Bench for qpi_phy_generic_4x: PHY_DELAY=0 and PHY_DELAY=4 instances share stimulus and are
// compared every cycle against a slot/sample-level model, plus hand-computed pins.
module tb_qpi_phy_generic_4x;

  logic clk_4x_s = 1'b0;
  always #5 clk_4x_s = ~clk_4x_s;

  logic        rst;
  logic        sync_4x;
  logic [15:0] phy_io_o;
  logic [3:0]  phy_io_oe;
  logic [3:0]  phy_clk_o;
  logic [0:0]  phy_cs_o;

  logic [15:0] d0_rx, d4_rx;
  logic        d0_stb, d4_stb;
  logic [3:0]  d0_po, d4_po, d0_oe, d4_oe, pad_i0, pad_i4;
  logic        d0_clk, d4_clk, d0_err, d4_err;
  logic [0:0]  d0_csn, d4_csn;

  logic        loop;
  logic [3:0]  rnd_in;
  logic [15:0] dly_line = '0;

  int total = 0;
  int bad   = 0;

  // DELAY=0 sees its own pads directly; DELAY=4 sees its pads through a 4-cycle round trip.
  assign pad_i0 = loop ? d0_po : rnd_in;
  assign pad_i4 = loop ? dly_line[15:12] : rnd_in;
  always @(posedge clk_4x_s) dly_line <= {dly_line[11:0], d4_po};

  qpi_phy_generic_4x #(.N_CS(1), .PHY_DELAY(0)) dut0 (
    .clk_4x_s(clk_4x_s), .rst(rst), .sync_4x(sync_4x),
    .phy_io_o(phy_io_o), .phy_io_oe(phy_io_oe), .phy_clk_o(phy_clk_o), .phy_cs_o(phy_cs_o),
    .phy_io_i(d0_rx), .phy_rx_stb(d0_stb),
    .pad_io_o(d0_po), .pad_io_oe(d0_oe), .pad_io_i(pad_i0), .pad_clk(d0_clk),
    .pad_cs_n(d0_csn), .sync_err(d0_err));

  qpi_phy_generic_4x #(.N_CS(1), .PHY_DELAY(4)) dut4 (
    .clk_4x_s(clk_4x_s), .rst(rst), .sync_4x(sync_4x),
    .phy_io_o(phy_io_o), .phy_io_oe(phy_io_oe), .phy_clk_o(phy_clk_o), .phy_cs_o(phy_cs_o),
    .phy_io_i(d4_rx), .phy_rx_stb(d4_stb),
    .pad_io_o(d4_po), .pad_io_oe(d4_oe), .pad_io_i(pad_i4), .pad_clk(d4_clk),
    .pad_cs_n(d4_csn), .sync_err(d4_err));

  task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: pads follow slot (edge - last sync) of the latest word; RX words come from recorded pad samples.
  logic [3:0]  pin0 [0:2047];
  logic [3:0]  pin4 [0:2047];
  logic [3:0]  mpo_arr [0:2047];
  int          ecnt = 0;
  int          last_sync = -1;
  logic [15:0] w_io;
  logic [3:0]  w_oe, w_clk;
  logic        w_cs;
  logic [3:0]  m_po = '0, m_oe = '0;
  logic        m_clk = 1'b0, m_csn = 1'b1, m_err = 1'b0;
  logic [15:0] m_rx0 = '0, m_rx4 = '0;
  logic        m_stb0 = 1'b0, m_stb4 = 1'b0;
  int          q0[$];
  int          q4[$];

  always @(posedge clk_4x_s) begin
    int e, k, s;
    e = ecnt;
    pin0[e] = loop ? ((e >= 1) ? mpo_arr[e-1] : 4'h0) : rnd_in;
    pin4[e] = loop ? ((e >= 5) ? mpo_arr[e-5] : 4'h0) : rnd_in;
    if (rst) begin
      m_po = '0; m_oe = '0; m_clk = 1'b0; m_csn = 1'b1; m_err = 1'b0;
      last_sync = -1;
      q0.delete(); q4.delete();
      m_rx0 = '0; m_rx4 = '0; m_stb0 = 1'b0; m_stb4 = 1'b0;
    end else begin
      if (sync_4x) begin
        if (last_sync >= 0 && e - last_sync <= 2) m_err = 1'b1;
        last_sync = e;
        w_io = phy_io_o; w_oe = phy_io_oe; w_clk = phy_clk_o; w_cs = phy_cs_o[0];
      end
      k = (last_sync >= 0) ? e - last_sync : 99;
      if (k <= 3) begin
        m_po = w_io[4*k +: 4]; m_oe = {4{w_oe[k]}}; m_clk = w_clk[k]; m_csn = ~w_cs;
      end else begin
        m_oe = '0; m_clk = 1'b0; m_csn = 1'b1;
      end
      m_stb0 = 1'b0;
      if (q0.size() > 0 && q0[0] + 5 == e) begin
        s = q0.pop_front();
        for (int j = 0; j < 4; j++) m_rx0[4*j +: 4] = pin0[s+j+1];
        m_stb0 = 1'b1;
      end
      m_stb4 = 1'b0;
      if (q4.size() > 0 && q4[0] + 9 == e) begin
        s = q4.pop_front();
        for (int j = 0; j < 4; j++) m_rx4[4*j +: 4] = pin4[s+j+5];
        m_stb4 = 1'b1;
      end
      if (sync_4x) begin
        q0.push_back(e);
        q4.push_back(e);
      end
    end
    mpo_arr[e] = m_po;
    ecnt++;
    #1;
    check_output("d0_pad_o", d0_po, m_po);    check_output("d4_pad_o", d4_po, m_po);
    check_output("d0_pad_oe", d0_oe, m_oe);   check_output("d4_pad_oe", d4_oe, m_oe);
    check_output("d0_pad_clk", d0_clk, m_clk); check_output("d4_pad_clk", d4_clk, m_clk);
    check_output("d0_cs_n", d0_csn, m_csn);   check_output("d4_cs_n", d4_csn, m_csn);
    check_output("d0_err", d0_err, m_err);    check_output("d4_err", d4_err, m_err);
    check_output("d0_rx", d0_rx, m_rx0);      check_output("d4_rx", d4_rx, m_rx4);
    check_output("d0_stb", d0_stb, m_stb0);   check_output("d4_stb", d4_stb, m_stb4);
  end

  task automatic apply_stimulus(input logic s, input logic [15:0] io, input logic [3:0] oe,
                                input logic [3:0] ck, input logic cs, input logic r);
    @(negedge clk_4x_s);
    sync_4x = s; phy_io_o = io; phy_io_oe = oe; phy_clk_o = ck; phy_cs_o = cs; rst = r;
    rnd_in = 4'($urandom_range(0, 15));
    @(posedge clk_4x_s);
    #2;
  endtask

  initial begin
    int gap, stb_cnt;
    logic s;
    logic [15:0] w;
    rst = 1'b1; sync_4x = 1'b0; phy_io_o = '0; phy_io_oe = '0; phy_clk_o = '0; phy_cs_o = '0;
    loop = 1'b0; rnd_in = '0;

    // Reset held while sync pulses: pads must stay idle.
    for (int i = 0; i < 6; i++) apply_stimulus(i[0], 16'hFFFF, 4'hF, 4'hF, 1'b1, 1'b1);
    check_output("rst_cs_n", d0_csn, 1'b1);
    check_output("rst_oe", d0_oe, 4'h0);
    check_output("rst_stb", d4_stb, 1'b0);
    apply_stimulus(0, 16'h0, 4'h0, 4'h0, 1'b0, 1'b0);
    apply_stimulus(0, 16'h0, 4'h0, 4'h0, 1'b0, 1'b0);

    // Loopback stream: A5C3, 1234, 5678 every 4 cycles.
    loop = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s = (i == 0 || i == 4 || i == 8);
      w = (i < 4) ? 16'hA5C3 : (i < 8) ? 16'h1234 : 16'h5678;
      apply_stimulus(s, w, 4'hF, 4'b1010, 1'b1, 1'b0);
      case (i)
        0: begin check_output("lit_slot0", d0_po, 4'h3); check_output("lit_clk0", d0_clk, 1'b0);
                 check_output("lit_csn0", d0_csn, 1'b0); end
        1: begin check_output("lit_slot1", d0_po, 4'hC); check_output("lit_clk1", d0_clk, 1'b1); end
        2: begin check_output("lit_slot2", d0_po, 4'h5); check_output("lit_clk2", d0_clk, 1'b0); end
        3: begin check_output("lit_slot3", d0_po, 4'hA); check_output("lit_clk3", d0_clk, 1'b1); end
        4: check_output("lit_csn4", d0_csn, 1'b0);
        5: begin check_output("lit_rx0_a5c3", d0_rx, 16'hA5C3); check_output("lit_stb0", d0_stb, 1'b1); end
        9: begin check_output("lit_rx0_1234", d0_rx, 16'h1234); check_output("lit_rx4_a5c3", d4_rx, 16'hA5C3); end
        12: begin check_output("lit_idle_oe", d0_oe, 4'h0); check_output("lit_idle_clk", d0_clk, 1'b0);
                  check_output("lit_idle_csn", d0_csn, 1'b1); check_output("lit_idle_err", d0_err, 1'b0); end
        13: begin check_output("lit_rx4_1234", d4_rx, 16'h1234); check_output("lit_stb4", d4_stb, 1'b1);
                  check_output("lit_rx0_5678", d0_rx, 16'h5678); end
        14: check_output("lit_stb4_once", d4_stb, 1'b0);
        17: check_output("lit_rx4_5678", d4_rx, 16'h5678);
        default: ;
      endcase
    end

    // Early sync two cycles into a word.
    loop = 1'b0;
    for (int i = 0; i < 10; i++) begin
      s = (i == 0 || i == 2 || i == 6);
      w = (i < 2) ? 16'h4321 : 16'h8765;
      apply_stimulus(s, w, 4'h5, 4'b0110, 1'b1, 1'b0);
      if (i == 2) begin
        check_output("lit_early_err", d0_err, 1'b1);
        check_output("lit_early_slot0", d0_po, 4'h5);
      end
      if (i == 3) check_output("lit_early_slot1", d0_po, 4'h6);
      if (i == 9) check_output("lit_err_sticky", d4_err, 1'b1);
    end

    // Reset two cycles into a word: no RX strobe may follow.
    stb_cnt = 0;
    for (int i = 0; i < 17; i++) begin
      apply_stimulus(i == 0, 16'hABCD, 4'hF, 4'hA, 1'b1, i == 2);
      if (i == 2) begin
        check_output("lit_rst_po", d0_po, 4'h0);
        check_output("lit_rst_csn", d0_csn, 1'b1);
        check_output("lit_rst_err", d0_err, 1'b0);
      end
      if (i >= 2 && (d0_stb || d4_stb)) stb_cnt++;
    end
    check_output("lit_no_stb", 16'(stb_cnt), 16'h0);

    // Randomized traffic with mostly nominal spacing, occasional early/late syncs and resets.
    gap = 0;
    for (int i = 0; i < 600; i++) begin
      if (i % 50 == 0) loop = 1'($urandom_range(0, 1));
      s = (gap <= 1);
      if (s) gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 4;
      else gap--;
      apply_stimulus(s, 16'($urandom), 4'($urandom), 4'($urandom), 1'($urandom),
                     $urandom_range(0, 149) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
